// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial arithmetic blocks.
// Holds the sequencer state enum, the default operand width and the counter sizing helper.
package serial_arith_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Bits needed to count 0 .. width-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_subtractor_1bit.sv
// One-bit full subtractor cell, the borrow counterpart of the serial adder's full-adder cell.
// Purely combinational: difference and borrow-out from a, b and borrow-in.
module full_subtractor_1bit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_d_c,
  output logic o_bout_c
);

  always_comb begin
    o_d_c    = i_a ^ i_b ^ i_bin;
    o_bout_c = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: one bit pair per clock, LSB first, registered borrow.
// Parallel operands in, parallel difference and final borrow out under a start/busy/done handshake.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a_data,
  input  logic [WIDTH-1:0] i_b_data,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow_out
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [WIDTH-1:0]   r_sra;
  logic [WIDTH-1:0]   r_srb;
  logic [WIDTH-1:0]   r_srd;
  logic               r_borrow;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_done;
  logic [WIDTH-1:0]   r_diff;
  logic               r_borrow_out;
  logic               w_d;
  logic               w_bo;
  logic               w_last;

  full_subtractor_1bit u_fs (
    .i_a      (r_sra[0]),
    .i_b      (r_srb[0]),
    .i_bin    (r_borrow),
    .o_d_c    (w_d),
    .o_bout_c (w_bo)
  );

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_start) w_state_nxt = SHIFT;
      SHIFT:   if (w_last)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, serial shift, and result commit on the final bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sra        <= '0;
      r_srb        <= '0;
      r_srd        <= '0;
      r_borrow     <= 1'b0;
      r_cnt        <= '0;
      r_done       <= 1'b0;
      r_diff       <= '0;
      r_borrow_out <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_sra    <= i_a_data;
            r_srb    <= i_b_data;
            r_srd    <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
          end
        end
        SHIFT: begin
          r_sra    <= r_sra >> 1;
          r_srb    <= r_srb >> 1;
          r_srd    <= {w_d, r_srd[WIDTH-1:1]};
          r_borrow <= w_bo;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_diff       <= {w_d, r_srd[WIDTH-1:1]};
            r_borrow_out <= w_bo;
            r_done       <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy       = (r_state == SHIFT);
  assign o_done       = r_done;
  assign o_diff       = r_diff;
  assign o_borrow_out = r_borrow_out;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks of serial_subtractor at WIDTH=8 and WIDTH=13.
module tb_serial_subtractor;

  logic        clk;
  logic        rst;

  logic        s8, busy8, done8, bo8;
  logic [7:0]  a8, b8, d8;
  logic        s13, busy13, done13, bo13;
  logic [12:0] a13, b13, d13;

  int n_vec;
  int n_err;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk          (clk),
    .rst          (rst),
    .i_start      (s8),
    .i_a_data     (a8),
    .i_b_data     (b8),
    .o_busy       (busy8),
    .o_done       (done8),
    .o_diff       (d8),
    .o_borrow_out (bo8)
  );

  serial_subtractor #(.WIDTH(13)) dut13 (
    .clk          (clk),
    .rst          (rst),
    .i_start      (s13),
    .i_a_data     (a13),
    .i_b_data     (b13),
    .o_busy       (busy13),
    .o_done       (done13),
    .o_diff       (d13),
    .o_borrow_out (bo13)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until done is seen (bounded); n is edges elapsed.
  task automatic wait_done8(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done8 && n < 40);
  endtask

  task automatic wait_done13(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done13 && n < 40);
  endtask

  // Full 8-bit operation; returns in the done cycle so a following call is back-to-back.
  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] exp_d, input logic exp_bo, input string tag);
    int n;
    a8 = a; b8 = b; s8 = 1'b1;
    tick();
    s8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    wait_done8(n);
    chk({tag, "_lat"}, 32'(n), 32'd8);
    chk({tag, "_diff"}, 32'(d8), 32'(exp_d));
    chk({tag, "_bo"}, 32'(bo8), 32'(exp_bo));
  endtask

  task automatic op13(input logic [12:0] a, input logic [12:0] b,
                      input logic [12:0] exp_d, input logic exp_bo, input string tag);
    int n;
    a13 = a; b13 = b; s13 = 1'b1;
    tick();
    s13 = 1'b0; a13 = 13'($urandom); b13 = 13'($urandom);
    wait_done13(n);
    chk({tag, "_lat"}, 32'(n), 32'd13);
    chk({tag, "_diff"}, 32'(d13), 32'(exp_d));
    chk({tag, "_bo"}, 32'(bo13), 32'(exp_bo));
  endtask

  initial begin
    int n;
    logic [7:0]  ra8, rb8;
    logic [12:0] ra13, rb13;
    n_vec = 0; n_err = 0;
    rst = 1'b1;
    s8 = 1'b0; a8 = '0; b8 = '0;
    s13 = 1'b0; a13 = '0; b13 = '0;
    tick(); tick();

    // Reset state; start is ignored while rst is high.
    s8 = 1'b1; a8 = 8'h33; b8 = 8'h11;
    tick();
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_diff", 32'(d8), 32'd0);
    chk("rst_bo", 32'(bo8), 32'd0);
    chk("rst_busy13", 32'(busy13), 32'd0);
    chk("rst_diff13", 32'(d13), 32'd0);
    s8 = 1'b0;
    rst = 1'b0;
    tick();

    // 5 - 3 with per-cycle busy/hold checks.
    a8 = 8'd5; b8 = 8'd3; s8 = 1'b1;
    tick();
    s8 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("b53_busy", 32'(busy8), 32'd1);
      chk("b53_done", 32'(done8), 32'd0);
      chk("b53_hold", 32'(d8), 32'd0);
      tick();
    end
    chk("b53_done_at8", 32'(done8), 32'd1);
    chk("b53_busy_at8", 32'(busy8), 32'd0);
    chk("b53_diff", 32'(d8), 32'h02);
    chk("b53_bo", 32'(bo8), 32'd0);
    tick();
    chk("b53_done_drop", 32'(done8), 32'd0);
    chk("b53_diff_hold", 32'(d8), 32'h02);

    // Directed corner vectors, issued back-to-back.
    op8(8'd3,  8'd5,  8'hFE, 1'b1, "m3_5");
    op8(8'h00, 8'h01, 8'hFF, 1'b1, "m0_1");
    op8(8'hFF, 8'hFF, 8'h00, 1'b0, "mff_ff");
    op8(8'h80, 8'h7F, 8'h01, 1'b0, "m80_7f");
    tick();
    chk("idle_done", 32'(done8), 32'd0);

    // start while busy is ignored; then a start in the done cycle is accepted.
    a8 = 8'd9; b8 = 8'd4; s8 = 1'b1;
    tick();
    s8 = 1'b0;
    tick(); tick();
    s8 = 1'b1; a8 = 8'h10; b8 = 8'h01;
    tick();
    s8 = 1'b0;
    wait_done8(n);
    chk("ign_lat", 32'(n + 3), 32'd8);
    chk("ign_diff", 32'(d8), 32'h05);
    chk("ign_bo", 32'(bo8), 32'd0);
    s8 = 1'b1; a8 = 8'h10; b8 = 8'h01;
    tick();
    s8 = 1'b0;
    wait_done8(n);
    chk("b2b_gap", 32'(n + 1), 32'd9);
    chk("b2b_diff", 32'(d8), 32'h0F);
    tick();
    chk("b2b_no_extra_done", 32'(done8), 32'd0);
    chk("b2b_no_queue", 32'(busy8), 32'd0);

    // rst in SHIFT cycle 4 discards the operation.
    a8 = 8'hA0; b8 = 8'h0F; s8 = 1'b1;
    tick();
    s8 = 1'b0;
    tick(); tick(); tick();
    chk("mid_busy", 32'(busy8), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy8), 32'd0);
    chk("mid_rst_done", 32'(done8), 32'd0);
    chk("mid_rst_diff", 32'(d8), 32'd0);
    chk("mid_rst_bo", 32'(bo8), 32'd0);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("mid_rst_no_done", 32'(done8), 32'd0);
    end
    op8(8'd7, 8'd2, 8'h05, 1'b0, "m7_2");

    // Directed 13-bit corners.
    op13(13'd5, 13'd3, 13'h0002, 1'b0, "w13_5_3");
    op13(13'h0000, 13'h0001, 13'h1FFF, 1'b1, "w13_0_1");
    op13(13'h1000, 13'h0FFF, 13'h0001, 1'b0, "w13_msb");

    // Randomized operands, expected from a+2^W-b arithmetic.
    for (int i = 0; i < 1000; i++) begin
      ra8 = 8'($urandom); rb8 = 8'($urandom);
      op8(ra8, rb8, 8'(ra8 - rb8), (ra8 < rb8), "rnd8");
    end
    for (int i = 0; i < 1000; i++) begin
      ra13 = 13'($urandom); rb13 = 13'($urandom);
      op13(ra13, rb13, 13'(ra13 - rb13), (ra13 < rb13), "rnd13");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor, the inverse of the team's bit-serial adder. It accepts two WIDTH-bit operands in parallel and processes one bit pair per clock, LSB first, carrying a registered borrow. It returns the difference a − b in parallel, plus the final borrow. It runs under a start/busy/done handshake so a controller can issue back-to-back operations without gaps.

## Interface
- WIDTH, default 8: operand and result width in bits; legal values are 2 and up.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request; sampled only while idle.
- a_data  in  WIDTH  minuend; captured on the accepting edge.
- b_data  in  WIDTH  subtrahend; captured on the accepting edge.
- busy  out  1  high while a subtraction is in progress.
- done  out  1  single-cycle pulse; result valid.
- diff  out  WIDTH  registered result, (a − b) mod 2^WIDTH.
- borrow_out  out  1  final borrow; 1 when a < b (unsigned).

## Operation
- Two states: IDLE and SHIFT.
- Reset: state IDLE; shift regs, counter, borrow flop cleared.
  - Outputs after reset: busy=0, done=0, diff=0, borrow_out=0.
- IDLE with start=1 at an edge:
  - Load sra←a_data, srb←b_data; clear srd, borrow, cnt.
  - Go to SHIFT; busy=1 from the next cycle.
- IDLE with start=0: hold everything; done is 0 after the pulse cycle.
- Each SHIFT cycle, with bits a0=sra[0] and b0=srb[0] and br=borrow flop:
  - d = a0^b0^br
  - bo = (~a0 & b0) | (~(a0^b0) & br)
  - sra and srb shift right by 1; srd shifts right with d entering the MSB.
  - borrow ← bo; cnt increments.
- Final SHIFT cycle (cnt == WIDTH−1), at the edge:
  - diff ← {d, srd[WIDTH−1:1]}; borrow_out ← bo; done ← 1.
  - Go to IDLE, busy ← 0.
- diff and borrow_out change only on a completion edge or on rst. They hold the previous result throughout busy and during idle.
- start while busy is ignored; there is no queueing, and operands are not re-sampled.
- a_data and b_data are don't-care except on the accepting edge.
- Signed use: borrow_out is the unsigned borrow. Signed overflow is not reported.

## Timing
- Start accepted at edge E0. Shift edges are E0+1 … E0+WIDTH.
- busy is high during the WIDTH cycles after E0.
- done, diff and borrow_out update at edge E0+WIDTH. Latency is WIDTH cycles from acceptance to done.
- Back-to-back operation: the done cycle is an IDLE cycle, so start=1 in that cycle is accepted at the next edge. Throughput is one operation per WIDTH+1 cycles. done still drops after one cycle.
- rst mid-operation (any SHIFT cycle) wins over everything:
  - The next cycle is IDLE with all outputs at reset values.
  - The partial result is discarded and no done is issued.
- rst and start both high at the same edge: rst wins and start is ignored.

## Structure
- Shared package serial_arith_pkg holds:
  - the state enum (IDLE, SHIFT);
  - the default WIDTH constant (8);
  - a counter-width function based on $clog2(WIDTH).
- One sub-module, full_subtractor_1bit, is purely combinational:
  - inputs a, b, bin; outputs d, bout.
  - It mirrors the 1-bit full adder cell used by the serial adder.
- Top level contains the FSM, cnt, the shift registers, the borrow flop, and the output registers.

## Test plan
- 5 − 3, WIDTH=8: busy for 8 cycles, then done for one cycle with diff=0x02, borrow_out=0. diff stays 0x00 during busy.
- 3 − 5: diff=0xFE, borrow_out=1. 0x00 − 0x01: diff=0xFF, borrow_out=1.
- 0xFF − 0xFF gives diff=0x00, borrow_out=0. 0x80 − 0x7F gives diff=0x01, borrow_out=0.
- start pulsed (with 0x10/0x01) on cycle 3 of a busy 9 − 4 operation:
  - Result is still diff=0x05 and no second done follows.
  - Then start=1 (0x10/0x01) in the done cycle: accepted, and the second done comes exactly 9 cycles after the first with diff=0x0F.
- rst asserted in SHIFT cycle 4 of 0xA0 − 0x0F: the next cycle has busy=0, done=0, diff=0, borrow_out=0. A new 7 − 2 then returns diff=0x05.
- 1000 random operand pairs for WIDTH=8 and WIDTH=13:
  - diff == (a − b) mod 2^WIDTH and borrow_out == (a < b).
  - done arrives exactly WIDTH cycles after acceptance every time.
